// File: rtl/gray_conv_sched.sv
// Four requesters time-share one 4-bit binary-to-Gray converter. A round-robin
// arbiter grants in IDLE, and the result is held until the downstream accepts it.
module gray_conv_sched #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [15:0]      bin_flat,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [1:0]       out_id,
    output logic [3:0]       out_gray,
    input  logic             out_ready,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       id_q, id_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_id_q, out_id_d;
    logic [3:0]       out_gray_q, out_gray_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    // Round-robin search: first set request at or above ptr, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        op_d        = op_q;
        id_d        = id_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_gray_d  = out_gray_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = 4'b0001 << win;
                    op_d    = bin_flat[{win, 2'b00} +: 4];
                    id_d    = win;
                    ptr_d   = win + 2'd1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                out_gray_d  = bin2gray(op_q);
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            op_q        <= '0;
            id_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_gray_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            id_q        <= id_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_gray_q  <= out_gray_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_gray  = out_gray_q;
    assign conv_cnt  = cnt_q;

endmodule

// File: doc/gray_conv_sched.md
GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-conversion counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per requester i; level, held high until gnt[i] is seen.
REQ-005 bin_flat  input  16  binary operands; requester i drives bin_flat[4i+3:4i]; stable while req[i] is high.
REQ-006 gnt  output  4  one-hot, one-cycle grant pulse; marks the sampled operand as consumed.
REQ-007 out_valid  output  1  converted result available.
REQ-008 out_id  output  2  index of the requester that owns out_gray.
REQ-009 out_gray  output  4  Gray code of the granted operand.
REQ-010 out_ready  input  1  downstream accepts the result when out_valid and out_ready are both high at a rising edge.
REQ-011 conv_cnt  output  CNT_W  count of accepted results, modulo 2^CNT_W.

Function
REQ-012 The block shall share one 4-bit binary-to-Gray converter among 4 requesters through FSM states IDLE, CONV and HOLD.
REQ-013 Conversion rule: G[3]=b[3], G[2]=b[3]^b[2], G[1]=b[2]^b[1], G[0]=b[1]^b[0].
REQ-014 IDLE, req==0: remain in IDLE; gnt=0.
REQ-015 IDLE, req!=0 at edge E: winner w is the first set bit searched from ptr upward, wrapping 3->0.
  - At E: gnt=onehot(w) for exactly one cycle; latch operand w and id w; ptr<=(w+1) mod 4; state<=CONV.
REQ-016 CONV at the next edge: out_gray<=G(latched operand); out_id<=w; out_valid<=1; gnt<=0; state<=HOLD.
REQ-017 HOLD while out_ready is low: out_valid, out_gray and out_id shall stay constant; no grants issued.
REQ-018 HOLD with out_ready high at an edge: out_valid<=0; conv_cnt<=conv_cnt+1 (wraps 2^CNT_W-1 -> 0); state<=IDLE.
REQ-019 Latency: req sampled at edge E -> gnt high after E; out_valid high after E+1; earliest acceptance at E+2; next grant no earlier than E+3.
REQ-020 Requests shall be sampled only in IDLE.
  - A req still high during CONV or HOLD is ignored until IDLE.
  - A requester that holds req high after its gnt shall be granted again under round-robin order.
REQ-021 Simultaneous requests: exactly one grant per IDLE visit.
  - Every continuously asserted request shall be granted within 4 grants (no starvation).
REQ-022 A change of a non-granted bin_flat slice after the grant edge shall not affect out_gray.
REQ-023 out_ready while out_valid is low shall have no effect.
REQ-024 Undefined FSM encodings shall return to IDLE on the next edge with out_valid=0 and gnt=0.

Reset
REQ-025 rst_n low shall immediately, without a clock edge, force:
  - state=IDLE, ptr=0, gnt=0, out_valid=0, out_id=0, out_gray=0, conv_cnt=0.
REQ-026 Reset asserted in CONV or HOLD shall discard the in-flight conversion, with no acceptance and no count increment.
REQ-027 After rst_n deasserts, the first edge with req!=0 shall arbitrate from ptr=0.

Verification
REQ-028 Single request: req=0001, bin_flat[3:0]=1011 -> gnt=0001 for one cycle, then out_valid=1, out_id=0, out_gray=1110; out_ready=1 -> conv_cnt=1.
REQ-029 Full sweep via requester 2: bin 0..15 -> out_gray equals bin^(bin>>1) each time (e.g. 0111->0100, 1111->1000); conv_cnt=16.
REQ-030 Contention: req=1111 held from reset, out_ready=1 -> grant order 0001,0010,0100,1000,0001; one grant every 3 cycles.
REQ-031 Backpressure: out_ready low 5 cycles in HOLD with req=0100 pending -> out_valid, out_gray and out_id constant; gnt=0; grant follows acceptance.
REQ-032 Reset mid-operation: rst_n pulsed low during CONV -> out_valid=0, gnt=0, conv_cnt=0 immediately; next grant goes to the lowest-index requester.
REQ-033 Counter wrap (CNT_W=8): 256 accepted results -> conv_cnt returns to 0.
